// File: rtl/data_shiftin_sync.sv
// ---------------------------------------------------------------------------
// data_shiftin_sync
// Serial word loader. It oversamples a host-driven t_clk/t_data pair in the
// clk domain, shifts REGISTER_WIDTH bits MSB first into a shadow register,
// and commits complete frames atomically to a held output word.
// Optional feature macro: SHIFTIN_PARITY_EN. When it is defined, one trailing
// odd-parity bit follows the payload. A frame with bad parity is not committed.
// ---------------------------------------------------------------------------
module data_shiftin_sync #(
    parameter int REGISTER_WIDTH = 129,
    parameter int SYNC_STAGES    = 2,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      t_clk_i,
    input  logic                      t_data_i,
    input  logic                      enable_i,
    output logic [REGISTER_WIDTH-1:0] reg_in_data_o,
    output logic                      ready_o,
    output logic                      busy_o,
    output logic                      overflow_o,
    output logic                      parity_err_o,
    output logic [CNT_WIDTH-1:0]      bit_count_o
);

`ifdef SHIFTIN_PARITY_EN
    localparam int FRAME_LEN = REGISTER_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] PAYLOAD_LEN_C = CNT_WIDTH'(REGISTER_WIDTH);
`else
    localparam int FRAME_LEN = REGISTER_WIDTH;
`endif
    localparam logic [CNT_WIDTH-1:0] FRAME_LEN_C = CNT_WIDTH'(FRAME_LEN);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE_C   = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

`ifdef SHIFTIN_PARITY_EN
    // Payload plus its trailing parity bit must have an odd number of ones.
    function automatic logic odd_parity_ok(input logic [REGISTER_WIDTH-1:0] payload,
                                           input logic                      pbit);
        odd_parity_ok = ^{payload, pbit};
    endfunction
`endif

    // Synchroniser chains; clock and data share depth so they stay aligned.
    logic [SYNC_STAGES-1:0] tclk_sync_q;
    logic [SYNC_STAGES-1:0] tdata_sync_q;
    logic [SYNC_STAGES-1:0] en_sync_q;
    logic                   tclk_prev_q;

    logic tclk_s;
    logic data_s;
    logic en_s;
    logic edge_s;
    logic frame_good_s;

    state_t                    state_q,      state_d;
    logic [REGISTER_WIDTH-1:0] shadow_q,     shadow_d;
    logic [REGISTER_WIDTH-1:0] reg_q,        reg_d;
    logic [CNT_WIDTH-1:0]      bit_count_q,  bit_count_d;
    logic                      ready_q,      ready_d;
    logic                      busy_q,       busy_d;
    logic                      overflow_q,   overflow_d;
`ifdef SHIFTIN_PARITY_EN
    logic                      parity_err_q, parity_err_d;
    logic                      parity_bit_q, parity_bit_d;
`endif

    assign tclk_s = tclk_sync_q[SYNC_STAGES-1];
    assign data_s = tdata_sync_q[SYNC_STAGES-1];
    assign en_s   = en_sync_q[SYNC_STAGES-1];
    assign edge_s = tclk_s & ~tclk_prev_q;

`ifdef SHIFTIN_PARITY_EN
    assign frame_good_s = odd_parity_ok(shadow_q, parity_bit_q);
`else
    assign frame_good_s = 1'b1;
`endif

    // Bring the asynchronous host signals into the clk domain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tclk_sync_q  <= '0;
            tdata_sync_q <= '0;
            en_sync_q    <= '0;
            tclk_prev_q  <= 1'b0;
        end else begin
            tclk_sync_q  <= {tclk_sync_q[SYNC_STAGES-2:0], t_clk_i};
            tdata_sync_q <= {tdata_sync_q[SYNC_STAGES-2:0], t_data_i};
            en_sync_q    <= {en_sync_q[SYNC_STAGES-2:0], enable_i};
            tclk_prev_q  <= tclk_s;
        end
    end

    // Frame FSM next state and datapath; enable low wins over any edge.
    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        reg_d        = reg_q;
        bit_count_d  = bit_count_q;
        ready_d      = ready_q;
        busy_d       = busy_q;
        overflow_d   = overflow_q;
`ifdef SHIFTIN_PARITY_EN
        parity_err_d = parity_err_q;
        parity_bit_d = parity_bit_q;
`endif
        if (!en_s) begin
            state_d      = ST_IDLE;
            shadow_d     = '0;
            bit_count_d  = '0;
            ready_d      = 1'b0;
            busy_d       = 1'b0;
            overflow_d   = 1'b0;
`ifdef SHIFTIN_PARITY_EN
            parity_err_d = 1'b0;
            parity_bit_d = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (edge_s) begin
`ifdef SHIFTIN_PARITY_EN
                        if (bit_count_q < PAYLOAD_LEN_C) begin
                            shadow_d = {shadow_q[REGISTER_WIDTH-2:0], data_s};
                        end else begin
                            parity_bit_d = data_s;
                        end
`else
                        shadow_d = {shadow_q[REGISTER_WIDTH-2:0], data_s};
`endif
                        if (bit_count_q < FRAME_LEN_C) begin
                            bit_count_d = bit_count_q + CNT_ONE_C;
                        end else begin
                            bit_count_d = bit_count_q;
                        end
                        if (bit_count_d == FRAME_LEN_C) begin
                            state_d = ST_COMMIT;
                            busy_d  = 1'b0;
                        end else begin
                            busy_d  = 1'b1;
                        end
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
                ST_COMMIT: begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    if (frame_good_s) begin
                        reg_d   = shadow_q;
                        ready_d = 1'b1;
                    end else begin
                        ready_d = 1'b0;
`ifdef SHIFTIN_PARITY_EN
                        parity_err_d = 1'b1;
`endif
                    end
                    if (edge_s) begin
                        overflow_d = 1'b1;
                    end else begin
                        overflow_d = overflow_q;
                    end
                end
                ST_DONE: begin
                    if (edge_s) begin
                        overflow_d = 1'b1;
                    end else begin
                        overflow_d = overflow_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Frame state and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            shadow_q     <= '0;
            reg_q        <= '0;
            bit_count_q  <= '0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
`ifdef SHIFTIN_PARITY_EN
            parity_err_q <= 1'b0;
            parity_bit_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            reg_q        <= reg_d;
            bit_count_q  <= bit_count_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            overflow_q   <= overflow_d;
`ifdef SHIFTIN_PARITY_EN
            parity_err_q <= parity_err_d;
            parity_bit_q <= parity_bit_d;
`endif
        end
    end

    assign reg_in_data_o = reg_q;
    assign ready_o       = ready_q;
    assign busy_o        = busy_q;
    assign overflow_o    = overflow_q;
    assign bit_count_o   = bit_count_q;
`ifdef SHIFTIN_PARITY_EN
    assign parity_err_o  = parity_err_q;
`else
    assign parity_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_data_shiftin_sync.sv
// ---------------------------------------------------------------------------
// tb_data_shiftin_sync
// Directed plus randomized frames against a bit-queue reference model:
// the committed word is the first REGISTER_WIDTH bits of a complete frame,
// and the counter, ready, busy, overflow and parity flags follow from how many
// bits the host has sent since enable rose.
// ---------------------------------------------------------------------------
module tb_data_shiftin_sync;

    localparam int W  = 129;
    localparam int S  = 2;
    localparam int CW = 8;
`ifdef SHIFTIN_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          t_clk;
    logic          t_data;
    logic          enable;
    logic [W-1:0]  reg_in_data;
    logic          ready;
    logic          busy;
    logic          overflow;
    logic          parity_err;
    logic [CW-1:0] bit_count;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] model_reg;
    logic [W-1:0] payload;

    data_shiftin_sync #(
        .REGISTER_WIDTH (W),
        .SYNC_STAGES    (S),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .t_clk_i       (t_clk),
        .t_data_i      (t_data),
        .enable_i      (enable),
        .reg_in_data_o (reg_in_data),
        .ready_o       (ready),
        .busy_o        (busy),
        .overflow_o    (overflow),
        .parity_err_o  (parity_err),
        .bit_count_o   (bit_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        for (int i = 0; i < W; i++) w[i] = 1'($urandom_range(0, 1));
        return w;
    endfunction

    // One host bit: data set first, clock high then low for S+2 clk cycles each.
    // With lat set, the ready rise is checked at S+1 and S+2 cycles after the rise.
    task automatic send_bit(input bit b, input bit lat);
        @(posedge clk); #1;
        t_data = b;
        @(posedge clk); #1;
        t_clk = 1'b1;
        if (lat) begin
            repeat (S + 1) @(posedge clk);
            @(negedge clk);
            chk("lat_early_ready", {255'd0, ready}, 256'd0);
            @(posedge clk);
            @(negedge clk);
            chk("lat_ready", {255'd0, ready}, 256'd1);
        end else begin
            repeat (S + 2) @(posedge clk);
        end
        #1 t_clk = 1'b0;
        repeat (S + 2) @(posedge clk);
    endtask

    task automatic arm();
        @(posedge clk); #1;
        enable = 1'b0;
        t_clk  = 1'b0;
        repeat (S + 3) @(posedge clk); #1;
        enable = 1'b1;
        repeat (S + 3) @(posedge clk);
    endtask

    task automatic abort_chk();
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (S + 3) @(posedge clk);
        @(negedge clk);
        chk("abort_count", {{(256-CW){1'b0}}, bit_count}, 256'd0);
        chk("abort_busy", {255'd0, busy}, 256'd0);
        chk("abort_ready", {255'd0, ready}, 256'd0);
        chk("abort_reg", {{(256-W){1'b0}}, reg_in_data}, {{(256-W){1'b0}}, model_reg});
    endtask

    // Send nbits of a frame built from payload (plus parity bit if enabled, plus
    // random extra bits), then compare against the model.
    task automatic run_frame(input logic [W-1:0] pl, input int nbits, input bit bad_par,
                             input bit lat);
        bit q[$];
        bit xr;
        bit complete;
        bit good;
        int exp_cnt;
        q = {};
        for (int i = W - 1; i >= 0; i--) q.push_back(pl[i]);
`ifdef SHIFTIN_PARITY_EN
        q.push_back(~(^pl) ^ bad_par);
`else
        if (bad_par) q.push_back(1'b0);
        if (bad_par) q.pop_back();
`endif
        while (q.size() < nbits) q.push_back(1'($urandom_range(0, 1)));
        arm();
        for (int i = 0; i < nbits; i++) begin
            send_bit(q[i], lat && (i == FL - 1));
            if (i + 1 >= FL) begin
                @(negedge clk);
                chk("overflow_step", {255'd0, overflow}, {255'd0, (i + 1 > FL)});
            end
        end
        complete = (nbits >= FL);
        xr = 1'b0;
        if (complete) begin
            for (int i = 0; i < FL; i++) xr = xr ^ q[i];
        end
`ifdef SHIFTIN_PARITY_EN
        good = complete && xr;
`else
        good = complete;
`endif
        if (good) model_reg = pl;
        exp_cnt = (nbits < FL) ? nbits : FL;
        @(negedge clk);
        chk("bit_count", {{(256-CW){1'b0}}, bit_count}, 256'(exp_cnt));
        chk("ready", {255'd0, ready}, {255'd0, good});
        chk("busy", {255'd0, busy}, {255'd0, (nbits > 0 && nbits < FL)});
        chk("overflow", {255'd0, overflow}, {255'd0, (nbits > FL)});
        chk("parity_err", {255'd0, parity_err}, {255'd0, (complete && !good)});
        chk("reg_in_data", {{(256-W){1'b0}}, reg_in_data}, {{(256-W){1'b0}}, model_reg});
    endtask

    initial begin
        rst       = 1'b1;
        t_clk     = 1'b0;
        t_data    = 1'b0;
        enable    = 1'b0;
        model_reg = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_reg", {{(256-W){1'b0}}, reg_in_data}, 256'd0);
        chk("rst_flags", {252'd0, ready, busy, overflow, parity_err}, 256'd0);
        chk("rst_count", {{(256-CW){1'b0}}, bit_count}, 256'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed word with exact commit latency.
        payload = {64'h0000_0000_0000_1234, 64'h0000_0000_0000_00FF, 1'b1};
        run_frame(payload, FL, 1'b0, 1'b1);

        // Reset for two cycles in the middle of a frame.
        arm();
        for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        @(negedge clk);
        chk("mid_count", {{(256-CW){1'b0}}, bit_count}, 256'd20);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reg = '0;
        chk("mrst_reg", {{(256-W){1'b0}}, reg_in_data}, 256'd0);
        chk("mrst_flags", {252'd0, ready, busy, overflow, parity_err}, 256'd0);
        chk("mrst_count", {{(256-CW){1'b0}}, bit_count}, 256'd0);
        #1 rst = 1'b0;

        // Good frame, abort after 50 bits, then a fresh full word.
        run_frame(rand_word(), FL, 1'b0, 1'b0);
        run_frame(rand_word(), 50, 1'b0, 1'b0);
        abort_chk();
        run_frame(rand_word(), FL, 1'b0, 1'b0);

        // Two edges past the end of the frame.
        run_frame(rand_word(), FL + 2, 1'b0, 1'b0);

`ifdef SHIFTIN_PARITY_EN
        run_frame(rand_word(), FL, 1'b0, 1'b0);
        run_frame(rand_word(), FL, 1'b1, 1'b0);
`endif

        // Enable falls on the same cycle as a synced edge.
        arm();
        for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        @(posedge clk); #1;
        t_clk  = 1'b1;
        enable = 1'b0;
        repeat (S + 3) @(posedge clk);
        @(negedge clk);
        chk("coinc_count", {{(256-CW){1'b0}}, bit_count}, 256'd0);
        chk("coinc_flags", {252'd0, ready, busy, overflow, parity_err}, 256'd0);
        chk("coinc_reg", {{(256-W){1'b0}}, reg_in_data}, {{(256-W){1'b0}}, model_reg});
        #1 t_clk = 1'b0;

        // Random frame lengths around the frame boundary.
        for (int k = 0; k < 5; k++) begin
            run_frame(rand_word(), $urandom_range(FL - 3, FL + 2), 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
